// File: rtl/apb_event_pkg.sv
// Shared definitions for the APB event completer.
// Address map, CTRL bit positions and completer FSM states.
package apb_event_pkg;

  localparam logic [3:0] ACC_A_ADDR = 4'h0;
  localparam logic [3:0] ACC_B_ADDR = 4'h4;
  localparam logic [3:0] ACC_C_ADDR = 4'h8;
  localparam logic [3:0] CTRL_ADDR  = 4'hC;

  localparam int CTRL_NZ_LSB  = 0;
  localparam int CTRL_SAT_LSB = 4;
  localparam int NUM_ACC      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/sat_accumulator.sv
// One saturating event accumulator with W1C-style clear.
// Sticky sat flag and combinational non-zero flag.
module sat_accumulator #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              add_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] acc,
  output logic              sat,
  output logic              nz
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, acc} + {1'b0, add_data};
  assign nz  = |acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (add_en) begin
      if (sum[DATA_W]) begin
        acc <= '1;
        sat <= 1'b1;
      end else begin
        acc <= sum[DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_event_completer.sv
// APB3 completer accumulating event writes into three saturating counters.
// Define APB_COMPLETER_WAIT_EN to insert one wait state per transfer.
module apb_event_completer
  import apb_event_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [2:0]        acc_nz_o,
  output logic [2:0]        sat_o
);

  apb_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic [DATA_W-1:0] acc [NUM_ACC];
  logic [NUM_ACC-1:0] add_en;
  logic [NUM_ACC-1:0] clr;

  logic              setup_seen;
  logic              commit;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_write;
  logic              dec_err;
  logic [3:0]        dec_word;
  logic [DATA_W-1:0] dec_rdata;
  logic [DATA_W-1:0] ctrl_word;

  assign setup_seen = psel_i & ~penable_i;

  // Response is computed on the edge that raises pready_o.
`ifdef APB_COMPLETER_WAIT_EN
  assign dec_addr  = addr_q;
  assign dec_write = write_q;
`else
  assign dec_addr  = paddr_i;
  assign dec_write = pwrite_i;
`endif

  assign dec_err  = ((dec_addr >> 4) != '0) || (dec_addr[1:0] != 2'b00);
  assign dec_word = {dec_addr[3:2], 2'b00};

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_NZ_LSB +: 3]  = acc_nz_o;
    ctrl_word[CTRL_SAT_LSB +: 3] = sat_o;
  end

  always_comb begin
    dec_rdata = '0;
    case (dec_word)
      ACC_A_ADDR: dec_rdata = acc[0];
      ACC_B_ADDR: dec_rdata = acc[1];
      ACC_C_ADDR: dec_rdata = acc[2];
      CTRL_ADDR:  dec_rdata = ctrl_word;
      default:    dec_rdata = '0;
    endcase
  end

  assign commit = (state == ACCESS) & psel_i & penable_i
                & write_q & ~pslverr_o;

  always_comb begin
    add_en = '0;
    clr    = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      add_en[i] = commit && (addr_q[3:2] == 2'(i));
      clr[i]    = commit && (addr_q[3:2] == 2'd3) && wdata_q[i];
    end
  end

  for (genvar i = 0; i < NUM_ACC; i++) begin : g_acc
    sat_accumulator #(
      .DATA_W(DATA_W)
    ) u_acc (
      .clk      (clk),
      .reset    (reset),
      .add_en   (add_en[i]),
      .clr      (clr[i]),
      .add_data (wdata_q),
      .acc      (acc[i]),
      .sat      (sat_o[i]),
      .nz       (acc_nz_o[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
      unique case (state)
        IDLE: begin
          if (setup_seen) begin
            addr_q  <= paddr_i;
            wdata_q <= pwdata_i;
            write_q <= pwrite_i;
`ifdef APB_COMPLETER_WAIT_EN
            state   <= SETUP;
`else
            state     <= ACCESS;
            pready_o  <= 1'b1;
            pslverr_o <= dec_err;
            prdata_o  <= (dec_err || dec_write) ? '0 : dec_rdata;
`endif
          end
        end
        SETUP: begin
          // Wait state; abandon if the initiator drops select.
          if (psel_i && penable_i) begin
            state     <= ACCESS;
            pready_o  <= 1'b1;
            pslverr_o <= dec_err;
            prdata_o  <= (dec_err || dec_write) ? '0 : dec_rdata;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_event_completer.sv
// Randomized self-checking bench for apb_event_completer.
// Reference model tracks accumulators with plain 33-bit arithmetic.
module tb_apb_event_completer;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef APB_COMPLETER_WAIT_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;
  logic [2:0]    acc_nz, sat;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int pq[$];

  logic [31:0] m_acc [3];
  logic [2:0]  m_sat;

  apb_event_completer #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .acc_nz_o  (acc_nz),
    .sat_o     (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pready === 1'b1) pq.push_back(cyc);

  function automatic logic [2:0] m_nz();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (m_acc[i] != 0);
    return r;
  endfunction

  function automatic logic m_err(input logic [7:0] a);
    return (a[7:4] != 0) || (a[1:0] != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] r;
    r = 0;
    if (m_err(a)) return 0;
    if (a[3:2] == 2'd3) begin
      r[2:0] = m_nz();
      r[6:4] = m_sat;
    end else begin
      r = m_acc[a[3:2]];
    end
    return r;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d);
    logic [32:0] s;
    if (m_err(a)) return;
    if (a[3:2] == 2'd3) begin
      for (int i = 0; i < 3; i++)
        if (d[i]) begin
          m_acc[i] = 0;
          m_sat[i] = 1'b0;
        end
    end else begin
      s = {1'b0, m_acc[a[3:2]]} + {1'b0, d};
      if (s > 33'h0_FFFF_FFFF) begin
        m_acc[a[3:2]] = 32'hFFFF_FFFF;
        m_sat[a[3:2]] = 1'b1;
      end else begin
        m_acc[a[3:2]] = s[31:0];
      end
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_acc[i] = 0;
    m_sat = 0;
  endtask

  task automatic xfer(input logic w, input logic [7:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic err, output int lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; rd = 0; err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pready === 1'b1) begin
        lat = i; rd = prdata; err = pslverr;
        break;
      end
    end
    if (lat != 0 && w) m_write(a, d);
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_write(input string nm, input logic [7:0] a,
                          input logic [31:0] d);
    logic [31:0] rd; logic err; int lat;
    logic exp_err;
    exp_err = m_err(a);
    xfer(1'b1, a, d, rd, err, lat);
    checks++;
    if (lat != EXP_LAT || err !== exp_err) begin
      fails++;
      $display("FAIL %s wr @%h: lat=%0d err=%b required lat=%0d err=%b",
               nm, a, lat, err, EXP_LAT, exp_err);
    end
    bus_idle();
  endtask

  task automatic do_read(input string nm, input logic [7:0] a);
    logic [31:0] rd, exp; logic err; int lat;
    exp = m_read(a);
    xfer(1'b0, a, 0, rd, err, lat);
    checks++;
    if (lat != EXP_LAT || rd !== exp || err !== m_err(a)) begin
      fails++;
      $display("FAIL %s rd @%h: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
               nm, a, rd, err, lat, exp, m_err(a), EXP_LAT);
    end
    bus_idle();
  endtask

  task automatic chk_flags(input string nm);
    checks++;
    if (acc_nz !== m_nz() || sat !== m_sat) begin
      fails++;
      $display("FAIL %s flags: acc_nz=%b sat=%b required acc_nz=%b sat=%b",
               nm, acc_nz, sat, m_nz(), m_sat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (prdata !== 0 || pready !== 0 || pslverr !== 0 ||
        acc_nz !== 0 || sat !== 0) begin
      fails++;
      $display("FAIL reset: prdata=%h pready=%b pslverr=%b nz=%b sat=%b required all 0",
               prdata, pready, pslverr, acc_nz, sat);
    end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_basic();
    do_write("basic", 8'h00, 32'h5);
    do_read("basic", 8'h00);
    chk_flags("basic");
  endtask

  task automatic test_saturation();
    do_write("sat", 8'h04, 32'hFFFF_FFF0);
    do_write("sat", 8'h04, 32'h20);
    do_read("sat", 8'h04);
    chk_flags("sat");
    do_write("sat_hold", 8'h04, 32'h1);
    do_read("sat_hold", 8'h04);
    do_read("sat_ctrl", 8'h0C);
  endtask

  task automatic test_clear();
    do_write("clr_load", 8'h00, 32'h11);
    do_write("clr_load", 8'h08, 32'h33);
    chk_flags("clr_load");
    do_write("clr", 8'h0C, 32'h7);
    for (int i = 0; i < 3; i++) do_read("clr", 8'(i * 4));
    do_read("clr_ctrl", 8'h0C);
    chk_flags("clr");
  endtask

  task automatic test_errors();
    do_write("err_load", 8'h00, 32'h9);
    do_write("err_hi", 8'h10, 32'h100);
    do_write("err_lo", 8'h02, 32'h100);
    do_read("err_rd", 8'h41);
    do_read("err_chk", 8'h00);
    chk_flags("err");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat, c0;
    int exp0, exp1;
    bus_idle();
    c0 = cyc + 1;
    pq.delete();
    xfer(1'b1, 8'h08, 32'hA5A5_0001, rd, err, lat);
    xfer(1'b0, 8'h08, 0, rd, err, lat);
    bus_idle();
    exp0 = c0 + 2 * EXP_LAT - 1 + (EXP_LAT - 1) * 0;
    exp0 = c0 + EXP_LAT;
    exp1 = c0 + 2 * EXP_LAT + 1 + (EXP_LAT - 1);
    checks++;
    if (rd !== m_read(8'h08) || err !== 1'b0) begin
      fails++;
      $display("FAIL b2b data: data=%h err=%b required data=%h err=0",
               rd, err, m_read(8'h08));
    end
    checks++;
    if (pq.size() != 2 || pq[0] != exp0 || pq[1] != exp1) begin
      fails++;
      $display("FAIL b2b pready: pulses=%0d first=%0d second=%0d required 2 at %0d %0d",
               pq.size(), pq.size() > 0 ? pq[0] - c0 + 1 : -1,
               pq.size() > 1 ? pq[1] - c0 + 1 : -1,
               exp0 - c0 + 1, exp1 - c0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    do_write("rst_pre", 8'h04, 32'h3);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 32'h7;
    @(posedge clk); #1;
    penable = 1;
    #2 reset = 1'b0;
    m_reset();
    #1;
    checks++;
    if (pready !== 0 || pslverr !== 0 || prdata !== 0 ||
        acc_nz !== 0 || sat !== 0) begin
      fails++;
      $display("FAIL rst_mid: pready=%b pslverr=%b prdata=%h nz=%b sat=%b required all 0",
               pready, pslverr, prdata, acc_nz, sat);
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(posedge clk); #1 reset = 1'b1;
    do_read("rst_mid", 8'h00);
    do_read("rst_mid", 8'h04);
  endtask

  task automatic test_random();
    logic [7:0] addrs [8];
    logic [31:0] rd, d, exp_rd; logic err, w; logic [7:0] a;
    logic [2:0] pre_nz, pre_sat;
    int lat;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h02, 8'h4D, 8'h08};
    for (int n = 0; n < 200; n++) begin
      a = addrs[$urandom_range(0, 7)];
      w = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       d = 32'hF000_0000 | $urandom;
        1:       d = $urandom;
        default: d = $urandom_range(0, 255);
      endcase
      if (a == 8'h0C && $urandom_range(0, 3) != 0) d = d & ~32'h7;
      exp_rd  = w ? 0 : m_read(a);
      pre_nz  = m_nz();
      pre_sat = m_sat;
      xfer(w, a, d, rd, err, lat);
      checks++;
      if (lat != EXP_LAT || err !== m_err(a) || rd !== exp_rd ||
          acc_nz !== pre_nz || sat !== pre_sat) begin
        fails++;
        $display("FAIL rand %0d %s @%h: data=%h err=%b lat=%0d nz=%b sat=%b required data=%h err=%b lat=%0d nz=%b sat=%b",
                 n, w ? "wr" : "rd", a, rd, err, lat, acc_nz, sat,
                 exp_rd, m_err(a), EXP_LAT, pre_nz, pre_sat);
      end
      if ($urandom_range(0, 1) == 1) bus_idle();
    end
    bus_idle();
    for (int i = 0; i < 4; i++) do_read("rand_end", 8'(i * 4));
    chk_flags("rand_end");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_clear();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
